// File: rtl/core_mem_arb_pkg.sv
// Shared types and width defaults for the core imem/dmem memory-port arbiter.
package core_mem_arb_pkg;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_t;

  localparam int ADDR_W_DEF    = 64;
  localparam int DATA_W_DEF    = 64;
  localparam int STRB_W_DEF    = 8;
  localparam int PRV_W_DEF     = 2;
  localparam int MAX_OUTST_DEF = 2;
  localparam int CNT_W_DEF     = $clog2(MAX_OUTST_DEF + 1);

  // Counter width able to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/core_mem_arb_owner_fifo.sv
// 1-bit synchronous FIFO recording which requester owns each in-flight transaction.
module core_mem_arb_owner_fifo
  import core_mem_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_DEF,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             din,
  output logic             full,
  output logic             empty,
  output logic             head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];
  assign count = cnt_q;

  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = nxt(wr_q);
    end
    if (pop_ok) rd_d = nxt(rd_q);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (imem) and load/store (dmem),
// with a grant lock while a request stalls and in-order response routing by owner.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int STRB_W    = STRB_W_DEF,
  parameter int PRV_W     = PRV_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic              g_clk,
  input  logic              g_reset,

  input  logic              imem_req,
  input  logic              imem_rtype,
  input  logic              imem_wen,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic [STRB_W-1:0] imem_strb,
  input  logic [DATA_W-1:0] imem_wdata,
  input  logic [PRV_W-1:0]  imem_prv,
  output logic              imem_gnt,
  output logic              imem_rsp,
  output logic              imem_err,
  output logic [DATA_W-1:0] imem_rdata,

  input  logic              dmem_req,
  input  logic              dmem_rtype,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [STRB_W-1:0] dmem_strb,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [PRV_W-1:0]  dmem_prv,
  output logic              dmem_gnt,
  output logic              dmem_rsp,
  output logic              dmem_err,
  output logic [DATA_W-1:0] dmem_rdata,

  output logic              mem_req,
  output logic              mem_rtype,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [STRB_W-1:0] mem_strb,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [PRV_W-1:0]  mem_prv,
  input  logic              mem_gnt,
  input  logic              mem_rsp,
  input  logic              mem_err,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              arb_proto_err
);

  localparam int CNT_W = cnt_w(MAX_OUTST);

  owner_t           sel, head_own;
  owner_t           last_q, last_d, lock_own_q, lock_own_d;
  logic             lock_q, lock_d;
  logic             proto_err_q, proto_err_d;
  logic             sel_req, accept, rsp_hit;
  logic             fifo_full, fifo_empty, fifo_head;
  logic [CNT_W-1:0] outst_cnt;

  always_comb begin
    sel = OWN_IMEM;
    if (lock_q)                     sel = lock_own_q;
    else if (imem_req && dmem_req)  sel = (last_q == OWN_IMEM) ? OWN_DMEM : OWN_IMEM;
    else if (dmem_req)              sel = OWN_DMEM;
    sel_req = (sel == OWN_DMEM) ? dmem_req : imem_req;
  end

  // Full is judged on the registered count only, so a same-cycle response never feeds mem_req.
  assign mem_req  = !g_reset && !fifo_full && sel_req;
  assign accept   = mem_req && mem_gnt;
  assign imem_gnt = accept && (sel == OWN_IMEM);
  assign dmem_gnt = accept && (sel == OWN_DMEM);

  always_comb begin
    mem_rtype = 1'b0;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_strb  = '0;
    mem_wdata = '0;
    mem_prv   = '0;
    if (mem_req) begin
      if (sel == OWN_DMEM) begin
        mem_rtype = dmem_rtype;
        mem_addr  = dmem_addr;
        mem_wen   = dmem_wen;
        mem_strb  = dmem_strb;
        mem_wdata = dmem_wdata;
        mem_prv   = dmem_prv;
      end else begin
        mem_rtype = imem_rtype;
        mem_addr  = imem_addr;
        mem_wen   = imem_wen;
        mem_strb  = imem_strb;
        mem_wdata = imem_wdata;
        mem_prv   = imem_prv;
      end
    end
  end

  always_comb begin
    lock_d      = lock_q;
    lock_own_d  = lock_own_q;
    last_d      = last_q;
    if (accept) begin
      lock_d = 1'b0;
      last_d = sel;
    end else if (mem_req) begin
      lock_d     = 1'b1;
      lock_own_d = sel;
    end
    proto_err_d = proto_err_q || (mem_rsp && (outst_cnt == '0));
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      lock_q      <= 1'b0;
      lock_own_q  <= OWN_IMEM;
      last_q      <= OWN_IMEM;
      proto_err_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      lock_own_q  <= lock_own_d;
      last_q      <= last_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign arb_proto_err = proto_err_q;

  core_mem_arb_owner_fifo #(
    .DEPTH (MAX_OUTST),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk   (g_clk),
    .rst   (g_reset),
    .push  (accept),
    .pop   (mem_rsp),
    .din   (sel),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head),
    .count (outst_cnt)
  );

  assign head_own   = owner_t'(fifo_head);
  assign rsp_hit    = !g_reset && mem_rsp && !fifo_empty;
  assign imem_rsp   = rsp_hit && (head_own == OWN_IMEM);
  assign dmem_rsp   = rsp_hit && (head_own == OWN_DMEM);
  assign imem_err   = imem_rsp && mem_err;
  assign dmem_err   = dmem_rsp && mem_err;
  assign imem_rdata = imem_rsp ? mem_rdata : '0;
  assign dmem_rdata = dmem_rsp ? mem_rdata : '0;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: vector table plus hand sequences, owner scoreboard for responses.
module tb_core_mem_arbiter;

  localparam logic [63:0] IA = 64'h1000;
  localparam logic [63:0] DA = 64'h2000;

  logic        g_clk, g_reset;
  logic        imem_req, imem_rtype, imem_wen, imem_gnt, imem_rsp, imem_err;
  logic [63:0] imem_addr, imem_wdata, imem_rdata;
  logic [7:0]  imem_strb;
  logic [1:0]  imem_prv;
  logic        dmem_req, dmem_rtype, dmem_wen, dmem_gnt, dmem_rsp, dmem_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_strb;
  logic [1:0]  dmem_prv;
  logic        mem_req, mem_rtype, mem_wen, mem_gnt, mem_rsp, mem_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_strb;
  logic [1:0]  mem_prv;
  logic        arb_proto_err;

  core_mem_arbiter dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .imem_req(imem_req), .imem_rtype(imem_rtype), .imem_wen(imem_wen), .imem_addr(imem_addr),
    .imem_strb(imem_strb), .imem_wdata(imem_wdata), .imem_prv(imem_prv), .imem_gnt(imem_gnt),
    .imem_rsp(imem_rsp), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_rtype(dmem_rtype), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_prv(dmem_prv), .dmem_gnt(dmem_gnt),
    .dmem_rsp(dmem_rsp), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_rtype(mem_rtype), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_prv(mem_prv), .mem_gnt(mem_gnt),
    .mem_rsp(mem_rsp), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .arb_proto_err(arb_proto_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic        ireq, dreq, mgnt, mrsp, merr;
    logic [63:0] rdata;
    logic        eig, edg, emreq;
    logic [63:0] eaddr;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_perr = 1'b0;
  logic sb[$];          // expected owner per accepted transaction: 0 = imem, 1 = dmem
  vec_t tbl[$];

  function automatic vec_t mk(input logic ireq, dreq, mgnt, mrsp, merr, input logic [63:0] rdata,
                              input logic eig, edg, emreq, input logic [63:0] eaddr);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.mgnt = mgnt; v.mrsp = mrsp; v.merr = merr; v.rdata = rdata;
    v.eig = eig; v.edg = edg; v.emreq = emreq; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, check mid-cycle, retire the response against the scoreboard, then clock.
  task automatic apply(input vec_t v);
    logic o;
    imem_req = v.ireq; dmem_req = v.dreq; mem_gnt = v.mgnt;
    mem_rsp = v.mrsp; mem_err = v.merr; mem_rdata = v.rdata;
    #4;
    chk("proto_err", arb_proto_err, exp_perr);
    chk("mem_req", mem_req, v.emreq);
    chk("imem_gnt", imem_gnt, v.eig);
    chk("dmem_gnt", dmem_gnt, v.edg);
    chk("mem_addr", mem_addr, v.eaddr);
    if (v.mrsp && sb.size() > 0) begin
      o = sb.pop_front();
      chk("imem_rsp", imem_rsp, !o);
      chk("dmem_rsp", dmem_rsp, o);
      chk("imem_rdata", imem_rdata, o ? 64'h0 : v.rdata);
      chk("dmem_rdata", dmem_rdata, o ? v.rdata : 64'h0);
      chk("imem_err", imem_err, !o && v.merr);
      chk("dmem_err", dmem_err, o && v.merr);
    end else begin
      chk("imem_rsp_idle", imem_rsp, 1'b0);
      chk("dmem_rsp_idle", dmem_rsp, 1'b0);
      if (v.mrsp) exp_perr = 1'b1;
    end
    if (v.eig) sb.push_back(1'b0);
    if (v.edg) sb.push_back(1'b1);
    @(posedge g_clk); #1;
  endtask

  task automatic do_reset();
    g_reset = 1'b1;
    imem_req = 1'b1; dmem_req = 1'b1; mem_gnt = 1'b1;
    mem_rsp = 1'b1; mem_err = 1'b0; mem_rdata = 64'h5a5a;
    #4;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_imem_gnt", imem_gnt, 1'b0);
    chk("rst_dmem_gnt", dmem_gnt, 1'b0);
    chk("rst_imem_rsp", imem_rsp, 1'b0);
    chk("rst_dmem_rsp", dmem_rsp, 1'b0);
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    sb.delete();
    exp_perr = 1'b0;
  endtask

  initial begin
    g_reset = 1'b1;
    imem_rtype = 1'b0; imem_wen = 1'b0; imem_addr = IA; imem_strb = 8'h00;
    imem_wdata = 64'h0; imem_prv = 2'd3;
    dmem_rtype = 1'b1; dmem_wen = 1'b1; dmem_addr = DA; dmem_strb = 8'hff;
    dmem_wdata = 64'hdead_beef; dmem_prv = 2'd0;
    imem_req = 1'b0; dmem_req = 1'b0; mem_gnt = 1'b0;
    mem_rsp = 1'b0; mem_err = 1'b0; mem_rdata = 64'h0;

    @(posedge g_clk); #1;
    do_reset();
    chk("rst_proto_err", arb_proto_err, 1'b0);

    // Round robin from reset: dmem wins the first tie, then alternate (D,I,D,I).
    tbl.push_back(mk(1,1,1,0,0,64'h0,  0,1,1,DA));
    tbl.push_back(mk(1,1,1,1,0,64'h11, 1,0,1,IA));
    tbl.push_back(mk(1,1,1,1,0,64'h22, 0,1,1,DA));
    tbl.push_back(mk(1,1,1,1,0,64'h33, 1,0,1,IA));
    tbl.push_back(mk(0,0,0,1,1,64'h44, 0,0,0,64'h0));
    // Make dmem the last winner so an unlocked tie would go to imem.
    tbl.push_back(mk(0,1,1,0,0,64'h0,  0,1,1,DA));
    tbl.push_back(mk(0,0,0,1,0,64'h55, 0,0,0,64'h0));
    // Lock: dmem stalls 3 cycles, imem joins, selection stays on dmem.
    tbl.push_back(mk(0,1,0,0,0,64'h0,  0,0,1,DA));
    tbl.push_back(mk(1,1,0,0,0,64'h0,  0,0,1,DA));
    tbl.push_back(mk(1,1,0,0,0,64'h0,  0,0,1,DA));
    tbl.push_back(mk(1,1,1,0,0,64'h0,  0,1,1,DA));
    tbl.push_back(mk(1,0,1,0,0,64'h0,  1,0,1,IA));
    tbl.push_back(mk(0,0,0,1,0,64'h66, 0,0,0,64'h0));
    tbl.push_back(mk(0,0,0,1,0,64'h77, 0,0,0,64'h0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Full at two outstanding; a same-cycle pop only frees the slot next cycle.
    apply(mk(1,1,1,0,0,64'h0,  0,1,1,DA));
    apply(mk(1,1,1,0,0,64'h0,  1,0,1,IA));
    apply(mk(1,1,1,0,0,64'h0,  0,0,0,64'h0));
    apply(mk(1,1,1,1,0,64'h88, 0,0,0,64'h0));
    apply(mk(1,1,1,0,0,64'h0,  0,1,1,DA));
    apply(mk(0,0,0,1,0,64'h99, 0,0,0,64'h0));
    apply(mk(0,0,0,1,1,64'hab, 0,0,0,64'h0));

    // In-order routing: imem then dmem, second response flagged as error.
    apply(mk(1,0,1,0,0,64'h0,  1,0,1,IA));
    apply(mk(0,1,1,0,0,64'h0,  0,1,1,DA));
    apply(mk(0,0,0,1,0,64'haa, 0,0,0,64'h0));
    apply(mk(0,0,0,1,1,64'hbb, 0,0,0,64'h0));

    // Response with nothing outstanding: dropped and sticky error.
    apply(mk(0,0,0,1,0,64'hcc, 0,0,0,64'h0));
    chk("proto_err_set", arb_proto_err, 1'b1);
    apply(mk(0,0,0,0,0,64'h0,  0,0,0,64'h0));
    apply(mk(1,0,1,0,0,64'h0,  1,0,1,IA));
    chk("proto_err_sticky", arb_proto_err, 1'b1);

    // Reset with transactions outstanding: they are forgotten.
    do_reset();
    chk("rst2_proto_err", arb_proto_err, 1'b0);
    apply(mk(0,0,0,1,0,64'hdd, 0,0,0,64'h0));
    chk("late_rsp_proto_err", arb_proto_err, 1'b1);
    apply(mk(1,1,1,0,0,64'h0,  0,1,1,DA));
    apply(mk(0,0,0,1,0,64'hee, 0,0,0,64'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
